// File: rtl/midi_spi_pkg.sv
// Shared note-event SPI frame format and transmit FSM state encodings.
// The same constants are used by the receiving spi_controller, so frames stay bit-exact.
package midi_spi_pkg;

    localparam int FRAME_BITS = 24;
    localparam int VOICE_MSB  = 23;
    localparam int VOICE_LSB  = 16;
    localparam int STATUS_BIT = 15;
    localparam int NOTE_MSB   = 14;
    localparam int NOTE_LSB   = 8;
    localparam int PAD_BIT    = 7;
    localparam int VEL_MSB    = 6;
    localparam int VEL_LSB    = 0;

    // Bit counter runs FRAME_BITS-1 down to 0.
    localparam int BIT_CNT_W  = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_GAP  = 2'd3
    } spi_state_e;

    // Assemble one note event into its on-wire frame; the pad bit is always zero.
    function automatic logic [FRAME_BITS-1:0] pack_note_frame(
        input logic       status,
        input logic [7:0] voice,
        input logic [6:0] note,
        input logic [6:0] vel
    );
        logic [FRAME_BITS-1:0] frame;
        frame                     = '0;
        frame[VOICE_MSB:VOICE_LSB] = voice;
        frame[STATUS_BIT]          = status;
        frame[NOTE_MSB:NOTE_LSB]   = note;
        frame[PAD_BIT]             = 1'b0;
        frame[VEL_MSB:VEL_LSB]     = vel;
        return frame;
    endfunction

endpackage

// File: rtl/spi_bit_timer.sv
// Half-period timer for the SPI transmitter: tick is high in the last clk cycle of
// each CLK_DIV-cycle SCLK half-period. The FSM pulses reload on every state entry.
module spi_bit_timer #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic reload,
    output logic tick
);

    localparam int              CNT_W    = $clog2(CLK_DIV + 1);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Reload on request, otherwise count down and hold at zero (never wraps).
    always_comb begin
        cnt_d = cnt_q;
        if (reload) begin
            cnt_d = LOAD_VAL;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == '0);

endmodule

// File: rtl/spi_note_tx.sv
// SPI transmit end of the note-event link: one note event per valid/ready handshake,
// sent as a 24-bit mode-0 frame (MSB first) followed by an idle gap with SCLK low.
// Optional feature macro SPI_NOTE_TX_CS_EN adds an active-low chip select SPI_cs_n.
module spi_note_tx
    import midi_spi_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       note_status,
    input  logic [7:0] voice_index,
    input  logic [6:0] midi_note,
    input  logic [6:0] velocity,
    output logic       SPI_sclk,
    output logic       SPI_mosi,
    output logic       busy,
    output logic       frame_done
`ifdef SPI_NOTE_TX_CS_EN
    ,
    output logic       SPI_cs_n
`endif
);

    localparam int               GAP_W    = $clog2(GAP_CYCLES + 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

    spi_state_e              state_q, state_d;
    logic [FRAME_BITS-1:0]   shift_q, shift_d;
    logic [BIT_CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0]        gap_cnt_q, gap_cnt_d;
    logic                    sclk_q, sclk_d;
    logic                    mosi_q, mosi_d;
    logic                    half_tick;
    logic                    timer_reload;

    spi_bit_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_bit_timer (
        .clk    (clk),
        .reset  (reset),
        .reload (timer_reload),
        .tick   (half_tick)
    );

    // Next-state logic: handshake, bit sequencing, shift and gap timing.
    // NOTE: every variable gets a default before the case, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    shift_d   = pack_note_frame(note_status, voice_index, midi_note, velocity);
                    bit_cnt_d = BIT_CNT_W'(FRAME_BITS - 1);
                    state_d   = ST_LOW;
                end
            end
            ST_LOW: begin
                if (half_tick) begin
                    state_d = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (half_tick) begin
                    shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
                    if (bit_cnt_q == '0) begin
                        gap_cnt_d = GAP_LOAD;
                        state_d   = ST_GAP;
                    end else begin
                        bit_cnt_d = bit_cnt_q - 1'b1;
                        state_d   = ST_LOW;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Line levels are decoded from the next state so the pins come straight from flops.
    always_comb begin
        sclk_d       = (state_d == ST_HIGH);
        mosi_d       = ((state_d == ST_LOW) || (state_d == ST_HIGH)) && shift_d[FRAME_BITS-1];
        timer_reload = (state_d != state_q);
    end

    // State, datapath and output registers.
    // NOTE: non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
        end
    end

    assign SPI_sclk   = sclk_q;
    assign SPI_mosi   = mosi_q;
    assign in_ready   = (state_q == ST_IDLE);
    assign busy       = ~in_ready;
    assign frame_done = (state_q == ST_GAP) && (gap_cnt_q == '0);

`ifdef SPI_NOTE_TX_CS_EN
    logic cs_n_q, cs_n_d;

    // Chip select is low from the accept edge until GAP is entered.
    always_comb begin
        cs_n_d = (state_d == ST_IDLE) || (state_d == ST_GAP);
    end

    // Chip select register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cs_n_q <= 1'b1;
        end else begin
            cs_n_q <= cs_n_d;
        end
    end

    assign SPI_cs_n = cs_n_q;
`endif

endmodule
